mux_n_arb: RTL and testbench
============================

Name: mux_n_arb

Overview:
- Parametrised N-input, WIDTH-bit selector that succeeds the fixed 3-input combinational datapath mux.
- Adds a valid/ready handshake on every input channel and a registered output stage.
- Supports two selection modes: explicit select (legacy) or round-robin arbitration.
- Used in the pipelined core wherever several producers (writeback sources, forwarding paths, memory response channels) feed one consumer that can stall.

Parameters:
WIDTH, 32, data width per channel.
N, 4, number of input channels (2..16).
SEL_W, 2, select/index width; must be ≥ ceil(log2(N)).
MODE, 0, 0 = explicit select via In_Sel; 1 = round-robin arbitration.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
In_Data  input  N*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
In_Valid  input  N  channel i holds valid data.
In_Ready  output  N  channel i is accepted this cycle if In_Valid[i] is also high.
In_Sel  input  SEL_W  channel select; MODE 0 only, ignored in MODE 1.
Out_Data  output  WIDTH  registered output data.
Out_Valid  output  1  Out_Data holds a valid beat.
Out_Ready  input  1  consumer accepts the beat when Out_Valid is also high.
Out_Chan  output  SEL_W  index of the channel that supplied Out_Data.

Behaviour:
- Reset (async, rst=1):
  - Out_Valid=0, Out_Data=0, Out_Chan=0, round-robin pointer=0.
  - In_Ready is all zero while rst is high.
  - Any beat held in the output register is discarded; there is no recovery.
- Reset timing: takes effect immediately. Deassertion is sampled at the next clk edge; the first acceptance is possible in the first cycle after deassertion.
- Output register: one entry.
  - can_accept = !Out_Valid || Out_Ready.
  - Full throughput: one beat per cycle when the consumer never stalls.
- Latency: input beat accepted at edge k appears on Out_Data/Out_Valid after edge k (1 cycle). No combinational path from In_Data to Out_Data.
- Grant index g (combinational):
  - MODE 0:
    - g = In_Sel if In_Sel < N-1, else N-1. This preserves the legacy rule: out-of-range and top codes select the last channel.
    - In_Ready[g] = can_accept; all other In_Ready bits are 0. In_Ready[g] does not depend on In_Valid[g].
  - MODE 1:
    - g = first i with In_Valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
    - If no channel is valid, all In_Ready=0 and there is no transfer.
    - Otherwise In_Ready[g] = can_accept; all other bits are 0.
- Transfer: occurs when In_Valid[g] && In_Ready[g]. Registers load Out_Data = channel g data, Out_Chan = g, Out_Valid = 1.
- Output drain: if Out_Valid && Out_Ready and there is no new transfer, Out_Valid clears at the next edge. Out_Data and Out_Chan hold their last values.
- Simultaneous drain and fill in the same cycle: the new beat replaces the old one, Out_Valid stays 1, and no bubble is inserted.
- Stall: Out_Valid && !Out_Ready → all In_Ready=0; Out_Data and Out_Chan stay stable until the beat is accepted.
- Round-robin pointer (MODE 1): after each transfer, ptr = (g+1) mod N, wrapping from N-1 to 0. ptr is unchanged when there is no transfer. This guarantees every continuously-valid channel is served within N transfers.
- Input protocol: a producer must hold In_Valid and In_Data stable until accepted. The block does not check this.
- MODE 0 select changes:
  - A change of In_Sel while a channel is stalled only moves the grant; no data is lost, since no beat is taken without a handshake.
  - The pointer is unused; it holds 0.

Test Plan:
1. MODE 0, N=4, Out_Ready=1, In_Sel=1, In_Valid=4'b1111, ch1=0x11111111 → at the next edge Out_Valid=1, Out_Data=0x11111111, Out_Chan=1. In_Ready=4'b0010 throughout.
2. MODE 0, In_Sel=3 (top code), and N=3 build with In_Sel=2'b11 → output is the last channel, matching legacy default-case behaviour.
3. Backpressure: hold Out_Ready=0 for 5 cycles with a beat in the output register → In_Ready=0 and Out_Data stable. Raise Out_Ready with In_Valid set → back-to-back beats, one per cycle, no bubble.
4. MODE 1, all four channels continuously valid with distinct data, Out_Ready=1 → Out_Chan sequence 0,1,2,3,0,1,…; the ptr wrap from 3 to 0 is checked.
5. MODE 1, only ch2 and ch0 valid, ptr=3 → first grant is 0, then 2, then 0. Channels with In_Valid=0 are never granted and never have In_Ready asserted.
6. Assert rst mid-stream with Out_Valid=1 → Out_Valid, Out_Data, Out_Chan drop to 0 immediately (asynchronously) and ptr=0. After release, the first accepted beat appears 1 cycle later and arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_n_arb_if.sv
// rtl/mux_n_arb_if.sv - channel/output handshake bundle for the N-input selector
interface mux_n_arb_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] In_Data;
    logic [N-1:0]       In_Valid;
    logic [N-1:0]       In_Ready;
    logic [SEL_W-1:0]   In_Sel;
    logic [WIDTH-1:0]   Out_Data;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [SEL_W-1:0]   Out_Chan;

    modport slave (
        input  In_Data,
        input  In_Valid,
        input  In_Sel,
        input  Out_Ready,
        output In_Ready,
        output Out_Data,
        output Out_Valid,
        output Out_Chan
    );

    modport master (
        output In_Data,
        output In_Valid,
        output In_Sel,
        output Out_Ready,
        input  In_Ready,
        input  Out_Data,
        input  Out_Valid,
        input  Out_Chan
    );
endinterface

// File: rtl/mux_n_arb.sv
// rtl/mux_n_arb.sv - N-input handshake selector, explicit-select or round-robin, registered output
module mux_n_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    mux_n_arb_if.slave    bus
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SEL_W-1:0]   out_chan_q;
    logic [SEL_W-1:0]   ptr_q;

    logic               can_accept;
    logic               grant_ok;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   scan_idx;
    int                 scan_sum;
    logic [N-1:0]       ready;
    logic               xfer;
    logic [WIDTH-1:0]   chan_data [N];
    logic [WIDTH-1:0]   sel_data;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = bus.In_Data[i*WIDTH +: WIDTH];
    end

    assign can_accept = !out_valid_q || bus.Out_Ready;

    // Round-robin scan runs from the far offset back to ptr so the closest valid channel wins.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        scan_sum = 0;
        scan_idx = '0;
        if (MODE == 0) begin
            grant    = (bus.In_Sel < LAST) ? bus.In_Sel : LAST;
            grant_ok = 1'b1;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                scan_sum = int'(ptr_q) + k;
                if (scan_sum >= N) begin
                    scan_sum = scan_sum - N;
                end
                scan_idx = SEL_W'(scan_sum);
                if (bus.In_Valid[scan_idx]) begin
                    grant    = scan_idx;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!rst && grant_ok && can_accept) begin
            ready[grant] = 1'b1;
        end
    end

    assign xfer     = ready[grant] && bus.In_Valid[grant];
    assign sel_data = chan_data[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_chan_q  <= grant;
            end else if (bus.Out_Ready) begin
                out_valid_q <= 1'b0;
            end
            // Pointer stays at zero in explicit-select builds.
            if (MODE == 1 && xfer) begin
                ptr_q <= (grant == LAST) ? '0 : grant + SEL_W'(1);
            end
        end
    end

    assign bus.In_Ready  = ready;
    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Chan  = out_chan_q;
endmodule

// File: tb/tb_mux_n_arb.sv
// tb/tb_mux_n_arb.sv - randomized and directed checks of mux_n_arb against a reference model
module tb_mux_n_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n_arb_if #(.WIDTH(32), .N(4), .SEL_W(2)) i0 ();
    mux_n_arb_if #(.WIDTH(32), .N(4), .SEL_W(2)) i1 ();
    mux_n_arb_if #(.WIDTH(32), .N(3), .SEL_W(2)) i2 ();

    mux_n_arb #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
    mux_n_arb #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    mux_n_arb #(.WIDTH(32), .N(3), .SEL_W(2), .MODE(0)) u2 (.clk(clk), .rst(rst), .bus(i2));

    int errors = 0;
    int checks = 0;

    int nn [3] = '{4, 4, 3};
    int md [3] = '{0, 1, 0};

    logic [31:0] dat  [3][4];
    logic [3:0]  vld  [3];
    logic [1:0]  sel  [3];
    logic        ordy [3];

    logic        mv   [3];
    logic [31:0] mdat [3];
    int          mch  [3];
    int          mptr [3];

    logic [3:0]  o_r;
    logic        o_v;
    logic [31:0] o_d;
    logic [1:0]  o_c;

    task automatic chk(input string tag, input int d, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs_v, exp_v);
        end
    endtask

    task automatic obs(input int d, output logic [3:0] r, output logic v,
                       output logic [31:0] dd, output logic [1:0] c);
        case (d)
            0: begin r = i0.In_Ready; v = i0.Out_Valid; dd = i0.Out_Data; c = i0.Out_Chan; end
            1: begin r = i1.In_Ready; v = i1.Out_Valid; dd = i1.Out_Data; c = i1.Out_Chan; end
            default: begin r = {1'b0, i2.In_Ready}; v = i2.Out_Valid; dd = i2.Out_Data; c = i2.Out_Chan; end
        endcase
    endtask

    task automatic drive();
        i0.In_Data  = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
        i0.In_Valid = vld[0];
        i0.In_Sel   = sel[0];
        i0.Out_Ready = ordy[0];
        i1.In_Data  = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
        i1.In_Valid = vld[1];
        i1.In_Sel   = sel[1];
        i1.Out_Ready = ordy[1];
        i2.In_Data  = {dat[2][2], dat[2][1], dat[2][0]};
        i2.In_Valid = vld[2][2:0];
        i2.In_Sel   = sel[2];
        i2.Out_Ready = ordy[2];
    endtask

    function automatic void reset_model();
        for (int d = 0; d < 3; d++) begin
            mv[d] = 1'b0; mdat[d] = '0; mch[d] = 0; mptr[d] = 0;
        end
    endfunction

    // Which channel the rules pick, or -1 when round-robin finds nothing valid.
    function automatic int mgrant(input int d);
        int s;
        if (md[d] == 0) begin
            s = int'(sel[d]);
            return (s < nn[d] - 1) ? s : nn[d] - 1;
        end
        for (int k = 0; k < nn[d]; k++) begin
            s = (mptr[d] + k) % nn[d];
            if (vld[d][s]) return s;
        end
        return -1;
    endfunction

    task automatic step();
        int         g  [3];
        logic [3:0] er [3];
        logic       xf [3];
        drive();
        #1;
        for (int d = 0; d < 3; d++) begin
            g[d]  = mgrant(d);
            er[d] = (!rst && g[d] >= 0 && (!mv[d] || ordy[d])) ? 4'(1 << g[d]) : 4'b0;
            xf[d] = 1'b0;
            if (er[d] != 0) xf[d] = vld[d][g[d]];
            obs(d, o_r, o_v, o_d, o_c);
            chk("in_ready", d, 32'(o_r), 32'(er[d]));
            chk("out_valid", d, 32'(o_v), 32'(mv[d]));
            chk("out_data", d, o_d, mdat[d]);
            chk("out_chan", d, 32'(o_c), 32'(mch[d]));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mv[d] = 1'b0; mdat[d] = '0; mch[d] = 0; mptr[d] = 0;
            end else if (xf[d]) begin
                mv[d] = 1'b1;
                mdat[d] = dat[d][g[d]];
                mch[d] = g[d];
                if (md[d] == 1) mptr[d] = (g[d] + 1) % nn[d];
            end else if (ordy[d]) begin
                mv[d] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) dat[d][k] = '0;
            vld[d] = '0; sel[d] = '0; ordy[d] = 1'b0;
        end
        reset_model();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Explicit select of channel 1 with every channel valid.
        for (int k = 0; k < 4; k++) dat[0][k] = $urandom;
        dat[0][1] = 32'h11111111;
        sel[0] = 2'd1; vld[0] = 4'hf; ordy[0] = 1'b1;
        step();
        obs(0, o_r, o_v, o_d, o_c);
        chk("t1_valid", 0, 32'(o_v), 32'd1);
        chk("t1_data", 0, o_d, 32'h11111111);
        chk("t1_chan", 0, 32'(o_c), 32'd1);
        chk("t1_ready", 0, 32'(o_r), 32'h2);

        // Top select code lands on the last channel for both N=4 and N=3.
        for (int k = 0; k < 3; k++) dat[2][k] = $urandom;
        sel[0] = 2'd3; sel[2] = 2'b11; vld[2] = 4'b0111; ordy[2] = 1'b1;
        step();
        obs(0, o_r, o_v, o_d, o_c);
        chk("t2_chan_n4", 0, 32'(o_c), 32'd3);
        chk("t2_data_n4", 0, o_d, dat[0][3]);
        obs(2, o_r, o_v, o_d, o_c);
        chk("t2_chan_n3", 2, 32'(o_c), 32'd2);
        chk("t2_data_n3", 2, o_d, dat[2][2]);

        // Five stalled cycles, then back-to-back beats.
        ordy[0] = 1'b0; sel[0] = 2'd2;
        for (int k = 0; k < 5; k++) begin
            dat[0][2] = $urandom;
            step();
        end
        obs(0, o_r, o_v, o_d, o_c);
        chk("t3_stall_data", 0, o_d, dat[0][3]);
        chk("t3_stall_ready", 0, 32'(o_r), 32'd0);
        ordy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dat[0][2] = $urandom;
            step();
            obs(0, o_r, o_v, o_d, o_c);
            chk("t3_b2b_valid", 0, 32'(o_v), 32'd1);
            chk("t3_b2b_data", 0, o_d, dat[0][2]);
        end

        // Asynchronous reset while a beat is held.
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            obs(d, o_r, o_v, o_d, o_c);
            chk("t6_rst_valid", d, 32'(o_v), 32'd0);
            chk("t6_rst_data", d, o_d, 32'd0);
            chk("t6_rst_chan", d, 32'(o_c), 32'd0);
            chk("t6_rst_ready", d, 32'(o_r), 32'd0);
        end
        reset_model();
        step();
        rst = 1'b0;

        // Round-robin with all channels valid restarts at channel 0 and wraps.
        for (int k = 0; k < 4; k++) dat[1][k] = 32'hA0000000 + 32'(k);
        vld[1] = 4'hf; ordy[1] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step();
            obs(1, o_r, o_v, o_d, o_c);
            chk("t4_rr_chan", 1, 32'(o_c), 32'(k % 4));
        end

        // Pointer now at 3; only channels 0 and 2 valid.
        vld[1] = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            obs(1, o_r, o_v, o_d, o_c);
            chk("t5_rr_chan", 1, 32'(o_c), (k == 1) ? 32'd2 : 32'd0);
            chk("t5_rr_ready_mask", 1, 32'(o_r & 4'b1010), 32'd0);
        end

        // Randomized traffic on all three instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 4; k++) dat[d][k] = $urandom;
                vld[d]  = 4'($urandom_range(0, 15));
                sel[d]  = 2'($urandom_range(0, 3));
                ordy[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
